alu_md: RTL and testbench

ALU_MD -- requirements
Module: alu_md

---
 rtl/alu_md.sv | 180 ++++++++++++++++++
 tb/tb_alu_md.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/alu_md.sv
// ALU plus iterative multiply/divide unit.
// The ALU is purely combinational; the multiply/divide unit is a two-state FSM
// that processes one operand bit per cycle and writes the Hi/Lo registers on completion.
// Define ALU_MD_DIV_EN to compile in the restoring divider (md_Op 2/3);
// without it, divide starts are ignored.
module alu_md #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] alu_Data1,
   input  logic [WIDTH-1:0] alu_Data2,
   input  logic [3:0]       alu_ALUOp,
   output logic [WIDTH-1:0] alu_Out,
   output logic             alu_Zero,
   output logic             alu_Isbgez,
   input  logic             md_Start,
   input  logic [1:0]       md_Op,
   input  logic             md_WriteHi,
   input  logic             md_WriteLo,
   output logic             md_Busy,
   output logic             md_Done,
   output logic [WIDTH-1:0] md_Hi,
   output logic [WIDTH-1:0] md_Lo
);

   localparam int unsigned SW = $clog2(WIDTH);

   typedef enum logic {StIdle, StRun} state_t;

   state_t           state_q;
   logic [SW-1:0]    cnt_q;
   logic [WIDTH-1:0] acc_q, mq_q, mcand_q, hi_q, lo_q;
   logic             neg_q, done_q;
`ifdef ALU_MD_DIV_EN
   logic             div_q, rneg_q, div0_q;
   logic [WIDTH:0]   shifted;
   logic             ge;
   logic [WIDTH-1:0] div_acc, div_mq, quo, rem;
`endif

   logic [SW-1:0]      shamt;
   logic               start_ok, op_signed, a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     sum;
   logic [WIDTH-1:0]   mul_acc, mul_mq, step_acc, step_mq, res_hi, res_lo;
   logic [2*WIDTH-1:0] prod;

   assign shamt      = alu_Data1[SW-1:0];
   assign alu_Zero   = (alu_Data1 == alu_Data2);
   assign alu_Isbgez = ~alu_Data1[WIDTH-1];
   assign md_Busy    = (state_q == StRun);
   assign md_Done    = done_q;
   assign md_Hi      = hi_q;
   assign md_Lo      = lo_q;

   // Combinational ALU result, independent of the multiply/divide unit
   always_comb begin
      alu_Out = '0;
      case (alu_ALUOp)
         4'd0:    alu_Out = alu_Data1 & alu_Data2;
         4'd1:    alu_Out = alu_Data1 | alu_Data2;
         4'd2:    alu_Out = alu_Data1 + alu_Data2;
         4'd3:    alu_Out = alu_Data1 - alu_Data2;
         4'd4:    alu_Out = {alu_Data2[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
         4'd5:    alu_Out = WIDTH'($signed(alu_Data2) >>> shamt);
         4'd6:    alu_Out = alu_Data2 >> shamt;
         4'd7:    alu_Out = alu_Data2 << shamt;
         4'd8:    alu_Out = alu_Data1 ^ alu_Data2;
         4'd9:    alu_Out = ~(alu_Data1 | alu_Data2);
         4'd10:   alu_Out = {{(WIDTH-1){1'b0}}, $signed(alu_Data1) < $signed(alu_Data2)};
         4'd11:   alu_Out = {{(WIDTH-1){1'b0}}, alu_Data1 < alu_Data2};
         default: alu_Out = '0;
      endcase
   end

   // Start decode and operand magnitudes; signed ops run on magnitudes and fix signs at the end
   always_comb begin
`ifdef ALU_MD_DIV_EN
      start_ok = md_Start;
`else
      start_ok = md_Start & ~md_Op[1];
`endif
      op_signed = ~md_Op[0];
      a_neg     = op_signed & alu_Data1[WIDTH-1];
      b_neg     = op_signed & alu_Data2[WIDTH-1];
      a_mag     = a_neg ? -alu_Data1 : alu_Data1;
      b_mag     = b_neg ? -alu_Data2 : alu_Data2;
   end

   // One iteration step and the sign-corrected result of the final step
   always_comb begin
      sum     = {1'b0, acc_q} + (mq_q[0] ? {1'b0, mcand_q} : '0);
      mul_acc = sum[WIDTH:1];
      mul_mq  = {sum[0], mq_q[WIDTH-1:1]};
      prod    = {mul_acc, mul_mq};
      if (neg_q) prod = -prod;
      step_acc = mul_acc;
      step_mq  = mul_mq;
      res_hi   = prod[2*WIDTH-1:WIDTH];
      res_lo   = prod[WIDTH-1:0];
`ifdef ALU_MD_DIV_EN
      shifted = {acc_q, mq_q[WIDTH-1]};
      ge      = (shifted >= {1'b0, mcand_q});
      // Remainder stays below the divisor, so the dropped top bit is always zero
      div_acc = ge ? WIDTH'(shifted - {1'b0, mcand_q}) : WIDTH'(shifted);
      div_mq  = {mq_q[WIDTH-2:0], ge};
      quo     = neg_q ? -div_mq : div_mq;
      rem     = rneg_q ? -div_acc : div_acc;
      // A zero divisor leaves the dividend magnitude in the remainder; only Lo needs forcing
      if (div0_q) quo = '1;
      if (div_q) begin
         step_acc = div_acc;
         step_mq  = div_mq;
         res_hi   = rem;
         res_lo   = quo;
      end
`endif
   end

   // Multiply/divide FSM, iteration datapath and Hi/Lo registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         acc_q   <= '0;
         mq_q    <= '0;
         mcand_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         neg_q   <= 1'b0;
         done_q  <= 1'b0;
`ifdef ALU_MD_DIV_EN
         div_q   <= 1'b0;
         rneg_q  <= 1'b0;
         div0_q  <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (start_ok) begin
                  state_q <= StRun;
                  cnt_q   <= '0;
                  acc_q   <= '0;
                  neg_q   <= a_neg ^ b_neg;
                  mq_q    <= b_mag;
                  mcand_q <= a_mag;
`ifdef ALU_MD_DIV_EN
                  div_q  <= md_Op[1];
                  rneg_q <= a_neg;
                  div0_q <= (alu_Data2 == '0);
                  if (md_Op[1]) begin
                     mq_q    <= a_mag;
                     mcand_q <= b_mag;
                  end
`endif
               end else if (!md_Start) begin
                  if (md_WriteHi) hi_q <= alu_Data1;
                  if (md_WriteLo) lo_q <= alu_Data1;
               end
            end
            StRun: begin
               acc_q <= step_acc;
               mq_q  <= step_mq;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == SW'(WIDTH - 1)) begin
                  state_q <= StIdle;
                  cnt_q   <= '0;
                  hi_q    <= res_hi;
                  lo_q    <= res_lo;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_md.sv
// Directed bench for alu_md at WIDTH=32; divide vectors apply when ALU_MD_DIV_EN is defined.
module tb_alu_md;

   logic        clk, rst_n;
   logic [31:0] alu_Data1, alu_Data2, alu_Out, md_Hi, md_Lo;
   logic [3:0]  alu_ALUOp;
   logic        alu_Zero, alu_Isbgez;
   logic        md_Start, md_WriteHi, md_WriteLo, md_Busy, md_Done;
   logic [1:0]  md_Op;

   int checks = 0;
   int errors = 0;

   alu_md #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_Data1(alu_Data1), .alu_Data2(alu_Data2), .alu_ALUOp(alu_ALUOp),
      .alu_Out(alu_Out), .alu_Zero(alu_Zero), .alu_Isbgez(alu_Isbgez),
      .md_Start(md_Start), .md_Op(md_Op), .md_WriteHi(md_WriteHi), .md_WriteLo(md_WriteLo),
      .md_Busy(md_Busy), .md_Done(md_Done), .md_Hi(md_Hi), .md_Lo(md_Lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, input string tag);
      alu_ALUOp = op;
      alu_Data1 = a;
      alu_Data2 = b;
      #1;
      check(tag, alu_Out, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts an operation from the current (idle) cycle and checks its length and result
   task automatic do_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input string tag);
      int n;
      md_Op = op;
      alu_Data1 = a;
      alu_Data2 = b;
      md_Start = 1'b1;
      tick();
      md_Start = 1'b0;
      alu_Data1 = ~a;
      alu_Data2 = ~b;
      check({tag, "_busy"}, 32'(md_Busy), 32'd1);
      check({tag, "_nodone"}, 32'(md_Done), 32'd0);
      n = 0;
      while (md_Busy && n < 100) begin
         tick();
         n++;
      end
      check({tag, "_cycles"}, n, 32'd32);
      check({tag, "_done"}, 32'(md_Done), 32'd1);
      check({tag, "_hi"}, md_Hi, ehi);
      check({tag, "_lo"}, md_Lo, elo);
   endtask

   initial begin
      int dn;
      rst_n = 1'b0;
      alu_Data1 = '0; alu_Data2 = '0; alu_ALUOp = '0;
      md_Start = 1'b0; md_Op = '0; md_WriteHi = 1'b0; md_WriteLo = 1'b0;
      #1;
      check("rst_busy", 32'(md_Busy), 32'd0);
      check("rst_done", 32'(md_Done), 32'd0);
      check("rst_hi", md_Hi, 32'd0);
      check("rst_lo", md_Lo, 32'd0);
      tick();
      tick();
      rst_n = 1'b1;

      // ALU
      alu(4'd0,  32'hF0F0_FF00, 32'h0FF0_F0F0, 32'h00F0_F000, "and");
      alu(4'd1,  32'hF0F0_FF00, 32'h0FF0_F0F0, 32'hFFF0_FFF0, "or");
      alu(4'd8,  32'hF0F0_FF00, 32'h0FF0_F0F0, 32'hFF00_0FF0, "xor");
      alu(4'd9,  32'hF0F0_FF00, 32'h0FF0_F0F0, 32'h000F_000F, "nor");
      alu(4'd2,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, "add_wrap");
      alu(4'd3,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, "sub_wrap");
      alu(4'd4,  32'h0000_0000, 32'h0000_1234, 32'h1234_0000, "lui");
      alu(4'd5,  32'h0000_0004, 32'h8000_0000, 32'hF800_0000, "sra");
      alu(4'd6,  32'h0000_0004, 32'h8000_0000, 32'h0800_0000, "srl");
      alu(4'd7,  32'h0000_0024, 32'h0000_0001, 32'h0000_0010, "sll_amt_lowbits");
      alu(4'd10, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, "slt");
      alu(4'd11, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, "sltu");
      alu(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "op12");
      check("zero_eq", 32'(alu_Zero), 32'd1);
      check("isbgez_neg", 32'(alu_Isbgez), 32'd0);
      alu(4'd15, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0000_0000, "op15");
      check("zero_ne", 32'(alu_Zero), 32'd0);
      check("isbgez_pos", 32'(alu_Isbgez), 32'd1);

      // Hi/Lo writes: both together, then Lo alone
      @(posedge clk); #1;
      alu_Data1 = 32'h1357_9BDF; md_WriteHi = 1'b1; md_WriteLo = 1'b1;
      tick();
      md_WriteHi = 1'b0;
      alu_Data1 = 32'h2468_ACE0;
      tick();
      md_WriteLo = 1'b0;
      check("wr_hi", md_Hi, 32'h1357_9BDF);
      check("wr_lo", md_Lo, 32'h2468_ACE0);

      // Multiplies; each start after the first lands in the previous Done cycle
      do_md(2'd0, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mult");
      do_md(2'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, "multu");
      do_md(2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_min");
      tick();
      check("done_pulse_end", 32'(md_Done), 32'd0);

`ifdef ALU_MD_DIV_EN
      do_md(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
      do_md(2'd3, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, "divu_zero");
      do_md(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_ovf");
      do_md(2'd3, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, "divu");
      tick();
`else
      // Divide start is ignored when the divider is not built
      md_Op = 2'd2; alu_Data1 = 32'd5; alu_Data2 = 32'd1; md_Start = 1'b1;
      tick();
      md_Start = 1'b0;
      check("nodiv_busy", 32'(md_Busy), 32'd0);
      dn = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (md_Done) dn++;
      end
      check("nodiv_done", dn, 32'd0);
      check("nodiv_hi", md_Hi, 32'h4000_0000);
      check("nodiv_lo", md_Lo, 32'h0000_0000);
`endif

      // Start and WriteHi during RUN are ignored
      md_Op = 2'd0; alu_Data1 = 32'd3; alu_Data2 = 32'd4; md_Start = 1'b1;
      tick();
      md_Start = 1'b0;
      dn = 0;
      for (int i = 1; i <= 45; i++) begin
         if (i == 5) begin
            md_Start = 1'b1; md_WriteHi = 1'b1; alu_Data1 = 32'd9; alu_Data2 = 32'd9;
         end else begin
            md_Start = 1'b0; md_WriteHi = 1'b0;
         end
         tick();
         if (md_Done) dn++;
      end
      check("busy_ign_done", dn, 32'd1);
      check("busy_ign_hi", md_Hi, 32'd0);
      check("busy_ign_lo", md_Lo, 32'd12);

      // Reset in the middle of RUN aborts the operation
      alu_Data1 = 32'hAAAA_5555; md_WriteHi = 1'b1;
      tick();
      md_WriteHi = 1'b0;
      check("pre_rst_hi", md_Hi, 32'hAAAA_5555);
      md_Op = 2'd1; alu_Data1 = 32'hFFFF_FFFF; alu_Data2 = 32'd2; md_Start = 1'b1;
      tick();
      md_Start = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(md_Busy), 32'd0);
      check("abort_hi", md_Hi, 32'd0);
      check("abort_lo", md_Lo, 32'd0);
      tick();
      rst_n = 1'b1;
      dn = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (md_Done) dn++;
      end
      check("abort_no_done", dn, 32'd0);
      check("abort_lo_after", md_Lo, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
